// File: rtl/serial_sync_framer_if.sv
// Signal bundle for serial_sync_framer: raw serial line in, aligned serial data and framing status out.
// master = line driver / status consumer, slave = framer.
interface serial_sync_framer_if;
  logic       RX_IN;
  logic       S_IN;
  logic       S_START;
  logic       LOCKED;
  logic       SYNC_ERR;
  logic       PAR_ERR;
  logic [7:0] FRAME_CNT;

  modport master (output RX_IN, input S_IN, S_START, LOCKED, SYNC_ERR, PAR_ERR, FRAME_CNT);
  modport slave  (input RX_IN, output S_IN, S_START, LOCKED, SYNC_ERR, PAR_ERR, FRAME_CNT);
endinterface

// File: rtl/serial_sync_framer.sv
// Serial sync-word framer: hunts for SYNC_WORD, verifies, locks with a flywheel, flags S_START per frame.
// Define FRAMER_PARITY_EN to add an even-parity bit after the 32 data bits (41-bit frame, PAR_ERR active).
module serial_sync_framer #(
  parameter logic [7:0]  SYNC_WORD   = 8'hA5,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned LOSS_FRAMES = 3
) (
  input logic                 CLK,
  input logic                 RESET,
  serial_sync_framer_if.slave bus
);

`ifdef FRAMER_PARITY_EN
  localparam int unsigned FRAME_BITS = 41;
  localparam int unsigned DATA_BITS  = 32;
`else
  localparam int unsigned FRAME_BITS = 40;
`endif
  localparam int unsigned CNT_W = 6;
  localparam int unsigned RUN_W = 3;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       hist_q;
  logic             s_in_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [RUN_W-1:0] good_q, good_d;
  logic [RUN_W-1:0] miss_q, miss_d;
  logic             s_start_q, s_start_d;
  logic             sync_err_q, sync_err_d;
  logic [7:0]       frame_cnt_q;
  logic             sync_hit_c;
  logic             frame_end_c;
  logic             lock_reached_c;
  logic             loss_reached_c;

  // bit_cnt_q == 0 while data bit 31 is on S_IN; the last sync bit sits at FRAME_BITS-1
  assign sync_hit_c     = (hist_q == SYNC_WORD);
  assign frame_end_c    = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
  assign lock_reached_c = ((good_q + RUN_W'(1)) == RUN_W'(LOCK_FRAMES));
  assign loss_reached_c = ((miss_q + RUN_W'(1)) == RUN_W'(LOSS_FRAMES));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_HUNT;
      hist_q      <= '0;
      s_in_q      <= 1'b0;
      bit_cnt_q   <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      s_start_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= {hist_q[6:0], bus.RX_IN};
      s_in_q      <= bus.RX_IN;
      bit_cnt_q   <= bit_cnt_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      s_start_q   <= s_start_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_q + 8'(s_start_d);
    end
  end

  // Next state: sync is only compared at the frame boundary once aligned
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    good_d    = good_q;
    miss_d    = miss_q;
    case (state_q)
      ST_HUNT: begin
        bit_cnt_d = '0;
        good_d    = '0;
        miss_d    = '0;
        if (sync_hit_c) begin
          good_d  = RUN_W'(1);
          state_d = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (frame_end_c) begin
          bit_cnt_d = '0;
          if (sync_hit_c) begin
            good_d = good_q + RUN_W'(1);
            if (lock_reached_c) state_d = ST_LOCKED;
          end else begin
            good_d  = '0;
            state_d = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (frame_end_c) begin
          bit_cnt_d = '0;
          if (sync_hit_c) begin
            miss_d = '0;
          end else if (loss_reached_c) begin
            miss_d  = '0;
            good_d  = '0;
            state_d = ST_HUNT;
          end else begin
            miss_d = miss_q + RUN_W'(1);
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Output pulses: S_START for every frame that begins with the framer locked
  always_comb begin
    s_start_d  = 1'b0;
    sync_err_d = 1'b0;
    case (state_q)
      ST_HUNT:   s_start_d = sync_hit_c && (LOCK_FRAMES == 1);
      ST_VERIFY: s_start_d = frame_end_c && sync_hit_c && lock_reached_c;
      ST_LOCKED: begin
        if (frame_end_c) begin
          sync_err_d = !sync_hit_c;
          s_start_d  = sync_hit_c || !loss_reached_c;
        end
      end
      default: ;
    endcase
  end

`ifdef FRAMER_PARITY_EN
  logic par_q, par_d;
  logic par_err_q, par_err_d;

  // Running XOR restarts on the first data bit of each frame
  always_comb begin
    par_d = par_q;
    if ((state_q == ST_HUNT) || frame_end_c) begin
      par_d = bus.RX_IN;
    end else if (bit_cnt_q < CNT_W'(DATA_BITS - 1)) begin
      par_d = par_q ^ bus.RX_IN;
    end
    par_err_d = (state_q == ST_LOCKED) && (bit_cnt_q == CNT_W'(DATA_BITS)) && (par_q ^ s_in_q);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign bus.PAR_ERR = par_err_q;
`else
  assign bus.PAR_ERR = 1'b0;
`endif

  assign bus.S_IN      = s_in_q;
  assign bus.S_START   = s_start_q;
  assign bus.LOCKED    = (state_q == ST_LOCKED);
  assign bus.SYNC_ERR  = sync_err_q;
  assign bus.FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_serial_sync_framer.sv
// Testbench for serial_sync_framer: directed and random bit streams checked against a frame-level model.
module tb_serial_sync_framer;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         LOCK_N = 2;
  localparam int         LOSS_N = 3;
`ifdef FRAMER_PARITY_EN
  localparam int F = 41;
`else
  localparam int F = 40;
`endif

  logic CLK;
  logic RESET;
  serial_sync_framer_if bus();

  serial_sync_framer #(
    .SYNC_WORD  (SYNC),
    .LOCK_FRAMES(LOCK_N),
    .LOSS_FRAMES(LOSS_N)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_run;
  int n_fail;

  // Observation word: {S_IN, S_START, LOCKED, SYNC_ERR, PAR_ERR, FRAME_CNT}
  logic        stim[$];
  logic [12:0] expv[$];
  logic [12:0] obs[$];

  function automatic logic [12:0] outs();
    return {bus.S_IN, bus.S_START, bus.LOCKED, bus.SYNC_ERR, bus.PAR_ERR, bus.FRAME_CNT};
  endfunction

  task automatic add_frame(input logic [7:0] sw, input logic [31:0] d, input bit bad_par);
    for (int k = 7; k >= 0; k--) stim.push_back(sw[k]);
    for (int k = 31; k >= 0; k--) stim.push_back(d[k]);
`ifdef FRAMER_PARITY_EN
    stim.push_back((^d) ^ bad_par);
`endif
  endtask

  // Last eight stream bits ending at index e (bits before the stream count as 0)
  function automatic logic [7:0] win(int e);
    logic [7:0] w;
    w = '0;
    for (int k = 7; k >= 0; k--) w = {w[6:0], (e - k >= 0) ? stim[e - k] : 1'b0};
    return w;
  endfunction

  // Frame-level reference: jump from decision point to decision point through the stream
  task automatic build_expected();
    int n;
    int t, mode, good, miss, lock_from, cnt;
    logic hit;
    bit st[], er[], lk[], pe[];
    n = stim.size();
    st = new[n]; er = new[n]; lk = new[n]; pe = new[n];
    t = 0; mode = 0; good = 0; miss = 0; lock_from = 0; cnt = 0;
    while (t < n) begin
      hit = (win(t - 1) == SYNC);
      if (mode == 0) begin
        if (hit) begin
          good = 1;
          if (LOCK_N == 1) begin mode = 2; lock_from = t; miss = 0; st[t] = 1; end
          else mode = 1;
          t += F;
        end else t++;
      end else if (mode == 1) begin
        if (hit) begin
          good++;
          if (good == LOCK_N) begin mode = 2; lock_from = t; miss = 0; st[t] = 1; end
          t += F;
        end else begin
          mode = 0; t++;
        end
      end else begin
        if (hit) begin
          miss = 0; st[t] = 1; t += F;
        end else begin
          er[t] = 1; miss++;
          if (miss == LOSS_N) begin
            for (int i = lock_from; i < t; i++) lk[i] = 1;
            mode = 0; t++;
          end else begin
            st[t] = 1; t += F;
          end
        end
      end
    end
    if (mode == 2) for (int i = lock_from; i < n; i++) lk[i] = 1;
`ifdef FRAMER_PARITY_EN
    for (int i = 0; i + 33 < n; i++) begin
      if (st[i]) begin
        logic p;
        p = 1'b0;
        for (int k = 0; k <= 32; k++) p ^= stim[i + k];
        pe[i + 33] = p;
      end
    end
`endif
    expv.delete();
    for (int i = 0; i < n; i++) begin
      cnt += int'(st[i]);
      expv.push_back({stim[i], st[i], lk[i], er[i], pe[i], 8'(cnt)});
    end
  endtask

  task automatic drive_stream();
    obs.delete();
    foreach (stim[i]) begin
      bus.RX_IN = stim[i];
      @(posedge CLK);
      #1;
      obs.push_back(outs());
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET     = 1'b0;
    bus.RX_IN = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  function automatic int count_bit(int pos);
    int c;
    c = 0;
    foreach (obs[i]) if (obs[i][pos]) c++;
    return c;
  endfunction

  function automatic int first_set(int pos, int from);
    for (int i = from; i < obs.size(); i++) if (obs[i][pos]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [12:0] v;
    bus.RX_IN = 1'b0;
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    #1;
    v = outs();
    n_run++;
    if (v !== 13'd0) begin n_fail++; $display("FAIL reset_initial: got %h expected 0", v); end
    @(negedge CLK);
    RESET = 1'b1;

    stim.delete();
    add_frame(SYNC, 32'hDEADBEEF, 0);
    add_frame(SYNC, 32'h12345678, 0);
    stim.push_back(1); stim.push_back(0); stim.push_back(1); stim.push_back(0);
    build_expected();
    drive_stream();
    foreach (obs[i]) begin
      n_run++;
      if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL reset_prefix cycle %0d: got %h expected %h", i, obs[i], expv[i]); end
    end
    n_run++;
    if (obs[obs.size() - 1][10] !== 1'b1) begin n_fail++; $display("FAIL reset_prelock: got LOCKED=%b expected 1", obs[obs.size() - 1][10]); end

    // Assert reset between edges; outputs must clear without waiting for a clock
    #2;
    RESET = 1'b0;
    #1;
    v = outs();
    n_run++;
    if (v !== 13'd0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", v); end
    @(negedge CLK);
    RESET = 1'b1;

    // Remaining sync bits only complete a match if the history survived reset
    stim.delete();
    stim.push_back(0); stim.push_back(1); stim.push_back(0); stim.push_back(1);
    add_frame(SYNC, 32'hCAFEF00D, 0);
    add_frame(SYNC, 32'h0BADC0DE, 0);
    build_expected();
    drive_stream();
    foreach (obs[i]) begin
      n_run++;
      if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL reset_restart cycle %0d: got %h expected %h", i, obs[i], expv[i]); end
    end
    n_run++;
    if (count_bit(11) !== 1) begin n_fail++; $display("FAIL reset_history_cleared: got %0d S_START expected 1", count_bit(11)); end
  endtask

  task automatic test_acquisition();
    int s;
    logic [31:0] w;
    do_reset();
    stim.delete();
    add_frame(SYNC, 32'hDEADBEEF, 0);
    add_frame(SYNC, 32'h12345678, 0);
    build_expected();
    drive_stream();
    foreach (obs[i]) begin
      n_run++;
      if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL acq_model cycle %0d: got %h expected %h", i, obs[i], expv[i]); end
    end
    n_run++;
    if (count_bit(11) !== 1) begin n_fail++; $display("FAIL acq_start_count: got %0d expected 1", count_bit(11)); end
    s = first_set(11, 0);
    n_run++;
    if (s !== 48) begin n_fail++; $display("FAIL acq_start_cycle: got %0d expected 48", s); end
    if (s >= 1 && s + 31 < obs.size()) begin
      n_run++;
      if (obs[s - 1][10] !== 1'b0 || obs[s][10] !== 1'b1) begin
        n_fail++; $display("FAIL acq_lock_rise: got %b%b expected 01", obs[s - 1][10], obs[s][10]);
      end
      for (int k = 0; k < 32; k++) w[31 - k] = obs[s + k][12];
      n_run++;
      if (w !== 32'h12345678) begin n_fail++; $display("FAIL acq_payload: got %h expected 12345678", w); end
      n_run++;
      if (obs[s][7:0] !== 8'd1) begin n_fail++; $display("FAIL acq_frame_cnt: got %0d expected 1", obs[s][7:0]); end
    end
  endtask

  task automatic test_flywheel();
    int l, drops;
    do_reset();
    stim.delete();
    add_frame(SYNC, $urandom, 0);
    add_frame(SYNC, $urandom, 0);
    add_frame(SYNC, $urandom, 0);
    add_frame(8'hA4, $urandom, 0);
    add_frame(SYNC, $urandom, 0);
    add_frame(SYNC, $urandom, 0);
    build_expected();
    drive_stream();
    foreach (obs[i]) begin
      n_run++;
      if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL fly_model cycle %0d: got %h expected %h", i, obs[i], expv[i]); end
    end
    n_run++;
    if (count_bit(9) !== 1) begin n_fail++; $display("FAIL fly_sync_err: got %0d expected 1", count_bit(9)); end
    n_run++;
    if (count_bit(11) !== 5) begin n_fail++; $display("FAIL fly_starts: got %0d expected 5", count_bit(11)); end
    l = first_set(10, 0);
    drops = (l < 0) ? 1 : 0;
    if (l >= 0) for (int i = l; i < obs.size(); i++) if (!obs[i][10]) drops++;
    n_run++;
    if (drops !== 0) begin n_fail++; $display("FAIL fly_lock_held: got %0d unlocked cycles expected 0", drops); end
  endtask

  task automatic test_loss();
    int e3, bad;
    do_reset();
    stim.delete();
    add_frame(SYNC, 32'h0, 0);
    add_frame(SYNC, 32'h0, 0);
    add_frame(8'hA4, 32'h0, 0);
    add_frame(8'hA4, 32'h0, 0);
    add_frame(8'hA4, 32'h0, 0);
    add_frame(SYNC, 32'h0, 0);
    add_frame(SYNC, 32'h0, 0);
    add_frame(SYNC, 32'h0, 0);
    build_expected();
    drive_stream();
    foreach (obs[i]) begin
      n_run++;
      if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL loss_model cycle %0d: got %h expected %h", i, obs[i], expv[i]); end
    end
    n_run++;
    if (count_bit(9) !== 3) begin n_fail++; $display("FAIL loss_sync_err: got %0d expected 3", count_bit(9)); end
    n_run++;
    if (count_bit(11) !== 5) begin n_fail++; $display("FAIL loss_starts: got %0d expected 5", count_bit(11)); end
    e3 = -1;
    foreach (obs[i]) if (obs[i][9]) e3 = i;
    if (e3 >= 1) begin
      n_run++;
      if (obs[e3 - 1][10] !== 1'b1 || obs[e3][10] !== 1'b0) begin
        n_fail++; $display("FAIL loss_lock_fall: got %b%b expected 10", obs[e3 - 1][10], obs[e3][10]);
      end
    end
    bad = 0;
    foreach (obs[i]) if (obs[i][11] && !obs[i][10]) bad++;
    n_run++;
    if (bad !== 0) begin n_fail++; $display("FAIL loss_start_unlocked: got %0d expected 0", bad); end
    n_run++;
    if (obs[obs.size() - 1][7:0] !== 8'd5) begin n_fail++; $display("FAIL loss_frame_cnt: got %0d expected 5", obs[obs.size() - 1][7:0]); end
  endtask

  task automatic test_false_sync();
    int prev, bad;
    do_reset();
    stim.delete();
    add_frame(SYNC, $urandom, 0);
    add_frame(SYNC, $urandom, 0);
    add_frame(SYNC, 32'h00A50000, 0);
    add_frame(SYNC, $urandom, 0);
    add_frame(SYNC, $urandom, 0);
    build_expected();
    drive_stream();
    foreach (obs[i]) begin
      n_run++;
      if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL false_model cycle %0d: got %h expected %h", i, obs[i], expv[i]); end
    end
    n_run++;
    if (count_bit(11) !== 4) begin n_fail++; $display("FAIL false_starts: got %0d expected 4", count_bit(11)); end
    prev = -1; bad = 0;
    foreach (obs[i]) begin
      if (obs[i][11]) begin
        if (prev >= 0 && i - prev != F) bad++;
        prev = i;
      end
    end
    n_run++;
    if (bad !== 0) begin n_fail++; $display("FAIL false_spacing: got %0d irregular gaps expected 0", bad); end
    n_run++;
    if (count_bit(9) !== 0) begin n_fail++; $display("FAIL false_sync_err: got %0d expected 0", count_bit(9)); end
  endtask

  task automatic test_parity();
    do_reset();
    stim.delete();
    add_frame(SYNC, $urandom, 0);
    add_frame(SYNC, $urandom, 0);
    add_frame(SYNC, 32'h00000001, 1);
    add_frame(SYNC, $urandom, 0);
    build_expected();
    drive_stream();
    foreach (obs[i]) begin
      n_run++;
      if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL par_model cycle %0d: got %h expected %h", i, obs[i], expv[i]); end
    end
`ifdef FRAMER_PARITY_EN
    begin
      int p, s2;
      n_run++;
      if (count_bit(8) !== 1) begin n_fail++; $display("FAIL par_err_count: got %0d expected 1", count_bit(8)); end
      p  = first_set(8, 0);
      s2 = first_set(11, first_set(11, 0) + 1);
      n_run++;
      if (p < 0 || s2 < 0 || p !== s2 + 33) begin n_fail++; $display("FAIL par_err_cycle: got %0d expected %0d", p, s2 + 33); end
      if (p >= 0) begin
        n_run++;
        if (obs[p][10] !== 1'b1) begin n_fail++; $display("FAIL par_lock: got LOCKED=%b expected 1", obs[p][10]); end
      end
      n_run++;
      if (count_bit(9) !== 0) begin n_fail++; $display("FAIL par_sync_err: got %0d expected 0", count_bit(9)); end
    end
`else
    n_run++;
    if (count_bit(8) !== 0) begin n_fail++; $display("FAIL par_tied_low: got %0d pulses expected 0", count_bit(8)); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] sw;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      stim.delete();
      repeat ($urandom_range(0, 45)) stim.push_back(1'($urandom));
      for (int f = 0; f < 12; f++) begin
        sw = SYNC;
        if ($urandom_range(0, 4) == 0) sw = SYNC ^ (8'd1 << $urandom_range(0, 7));
        add_frame(sw, $urandom, $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) stim.push_back(1'($urandom));
      end
      build_expected();
      drive_stream();
      foreach (obs[i]) begin
        n_run++;
        if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL rand%0d cycle %0d: got %h expected %h", it, i, obs[i], expv[i]); end
      end
    end
  endtask

  task automatic test_frame_cnt_wrap();
    do_reset();
    stim.delete();
    for (int f = 0; f < 258; f++) add_frame(SYNC, $urandom, 0);
    build_expected();
    drive_stream();
    foreach (obs[i]) begin
      n_run++;
      if (obs[i] !== expv[i]) begin n_fail++; $display("FAIL wrap_model cycle %0d: got %h expected %h", i, obs[i], expv[i]); end
    end
    n_run++;
    if (obs[obs.size() - 1][7:0] !== 8'd1) begin n_fail++; $display("FAIL wrap_frame_cnt: got %0d expected 1", obs[obs.size() - 1][7:0]); end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    bus.RX_IN = 1'b0;
    test_reset();
    test_acquisition();
    test_flywheel();
    test_loss();
    test_false_sync();
    test_parity();
    test_random();
    test_frame_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
